// File: rtl/ddr_mc_burst_arbiter_if.sv
// Bundle of client-side and ddr_controller-side signals for the N-client burst arbiter.
// err_timeout exists only when DDR_ARB_TIMEOUT_EN is defined.
interface ddr_mc_burst_arbiter_if #(
    parameter int NUM_CLIENTS    = 4,
    parameter int DDR_DATA_WIDTH = 128,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int CL_DATA_WIDTH  = 32,
    parameter int LEN_WIDTH      = 10
);
    localparam int CIW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    logic [NUM_CLIENTS-1:0]                cl_req;
    logic [NUM_CLIENTS-1:0]                cl_wr;
    logic [NUM_CLIENTS*DDR_ADDR_WIDTH-1:0] cl_addr;
    logic [NUM_CLIENTS*LEN_WIDTH-1:0]      cl_len;
    logic [NUM_CLIENTS*CL_DATA_WIDTH-1:0]  cl_wdata;
    logic [NUM_CLIENTS-1:0]                cl_ack;
    logic [NUM_CLIENTS-1:0]                cl_wdata_req;
    logic [CL_DATA_WIDTH-1:0]              cl_rdata;
    logic [NUM_CLIENTS-1:0]                cl_rvalid;
    logic [NUM_CLIENTS-1:0]                cl_done;
    logic                                  busy;
    logic [CIW-1:0]                        cur_client;

    logic                                  rd_burst_req;
    logic                                  wr_burst_req;
    logic [LEN_WIDTH-1:0]                  rd_burst_len;
    logic [LEN_WIDTH-1:0]                  wr_burst_len;
    logic [DDR_ADDR_WIDTH-1:0]             rd_burst_addr;
    logic [DDR_ADDR_WIDTH-1:0]             wr_burst_addr;
    logic [DDR_DATA_WIDTH-1:0]             wr_burst_data;
    logic [DDR_DATA_WIDTH-1:0]             rd_burst_data;
    logic                                  rd_burst_data_valid;
    logic                                  wr_burst_data_req;
    logic                                  rd_burst_finish;
    logic                                  wr_burst_finish;
`ifdef DDR_ARB_TIMEOUT_EN
    logic                                  err_timeout;
`endif

    // Arbiter view: serves the clients, drives the ddr_controller burst port.
    modport slave (
        input  cl_req, cl_wr, cl_addr, cl_len, cl_wdata,
        output cl_ack, cl_wdata_req, cl_rdata, cl_rvalid, cl_done, busy, cur_client,
        output rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
        output rd_burst_addr, wr_burst_addr, wr_burst_data,
        input  rd_burst_data, rd_burst_data_valid, wr_burst_data_req,
        input  rd_burst_finish, wr_burst_finish
`ifdef DDR_ARB_TIMEOUT_EN
        , output err_timeout
`endif
    );

    // Environment view: the clients plus the ddr_controller.
    modport master (
        output cl_req, cl_wr, cl_addr, cl_len, cl_wdata,
        input  cl_ack, cl_wdata_req, cl_rdata, cl_rvalid, cl_done, busy, cur_client,
        input  rd_burst_req, wr_burst_req, rd_burst_len, wr_burst_len,
        input  rd_burst_addr, wr_burst_addr, wr_burst_data,
        output rd_burst_data, rd_burst_data_valid, wr_burst_data_req,
        output rd_burst_finish, wr_burst_finish
`ifdef DDR_ARB_TIMEOUT_EN
        , input err_timeout
`endif
    );
endinterface

// File: rtl/ddr_mc_burst_arbiter.sv
// Round-robin arbiter of NUM_CLIENTS burst requesters onto one ddr_controller port.
// Optional burst watchdog with sticky err_timeout: define DDR_ARB_TIMEOUT_EN.
module ddr_mc_burst_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int DDR_DATA_WIDTH = 128,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int CL_DATA_WIDTH  = 32,
    parameter int LEN_WIDTH      = 10,
    parameter int MAX_BURST      = 128,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,
    ddr_mc_burst_arbiter_if.slave    bus
);
    localparam int CIW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_BURST, ST_FINISH} state_t;

    function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
        if (len > LEN_WIDTH'(MAX_BURST)) return LEN_WIDTH'(MAX_BURST);
        return len;
    endfunction

    function automatic logic [DDR_DATA_WIDTH-1:0] widen_wdata(input logic [CL_DATA_WIDTH-1:0] d);
        return DDR_DATA_WIDTH'(d);
    endfunction

    function automatic logic [NUM_CLIENTS-1:0] onehot(input logic [CIW-1:0] idx);
        logic [NUM_CLIENTS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First requester strictly after ptr, wrapping; ptr itself is checked last.
    function automatic logic [CIW-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                               input logic [CIW-1:0]         ptr);
        logic [CIW-1:0] pick;
        logic           found;
        int             idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_CLIENTS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
            if (!found && req[CIW'(idx)]) begin
                pick  = CIW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [CIW-1:0]             r_ptr;
    logic [CIW-1:0]             r_cur;
    logic                       r_wr;
    logic [DDR_ADDR_WIDTH-1:0]  r_addr;
    logic [LEN_WIDTH-1:0]       r_len;
    logic [LEN_WIDTH-1:0]       r_beats;
    logic [NUM_CLIENTS-1:0]     r_ack;
    logic [NUM_CLIENTS-1:0]     r_done;
    logic [NUM_CLIENTS-1:0]     r_rvalid;
    logic [CL_DATA_WIDTH-1:0]   r_rdata;
    logic                       r_rd_req;
    logic                       r_wr_req;
    logic [LEN_WIDTH-1:0]       r_rd_len;
    logic [LEN_WIDTH-1:0]       r_wr_len;
    logic [DDR_ADDR_WIDTH-1:0]  r_rd_addr;
    logic [DDR_ADDR_WIDTH-1:0]  r_wr_addr;
    logic [DDR_DATA_WIDTH-1:0]  r_wdata;

    logic                       w_grant;
    logic                       w_ddr_start;
    logic                       w_burst_end;
    logic                       w_tmo_hit;
    logic                       w_finish_in;
    logic [CIW-1:0]             w_winner;
    logic                       w_unused_rd;

    logic [DDR_ADDR_WIDTH-1:0]  w_addr_arr  [NUM_CLIENTS];
    logic [LEN_WIDTH-1:0]       w_len_arr   [NUM_CLIENTS];
    logic [CL_DATA_WIDTH-1:0]   w_wdata_arr [NUM_CLIENTS];

    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
        assign w_addr_arr[g]  = bus.cl_addr[g*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
        assign w_len_arr[g]   = bus.cl_len[g*LEN_WIDTH +: LEN_WIDTH];
        assign w_wdata_arr[g] = bus.cl_wdata[g*CL_DATA_WIDTH +: CL_DATA_WIDTH];
    end

    // Only the low CL_DATA_WIDTH bits of a read beat reach the clients.
    assign w_unused_rd = &{1'b0, bus.rd_burst_data};

    assign w_winner    = rr_pick(bus.cl_req, r_ptr);
    assign w_finish_in = r_wr ? bus.wr_burst_finish : bus.rd_burst_finish;

`ifdef DDR_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;
    logic          r_err;

    assign w_tmo_hit = (r_state == ST_BURST) && !w_finish_in &&
                       (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == ST_GRANT)      r_tmo <= '0;
            else if (r_state == ST_BURST) r_tmo <= r_tmo + 1'b1;
            if (w_tmo_hit)                r_err <= 1'b1;
        end
    end

    assign bus.err_timeout = r_err;
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge mem_clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_ddr_start = 1'b0;
        w_burst_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|bus.cl_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (r_len == '0) begin
                    w_state_nxt = ST_FINISH;
                end else begin
                    w_ddr_start = 1'b1;
                    w_state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (w_finish_in || w_tmo_hit) begin
                    w_burst_end = 1'b1;
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, DDR command and beat routing
    always_ff @(posedge mem_clk) begin
        if (!rst_n) begin
            r_ptr     <= CIW'(NUM_CLIENTS - 1);
            r_cur     <= '0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_beats   <= '0;
            r_ack     <= '0;
            r_done    <= '0;
            r_rvalid  <= '0;
            r_rdata   <= '0;
            r_rd_req  <= 1'b0;
            r_wr_req  <= 1'b0;
            r_rd_len  <= '0;
            r_wr_len  <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wdata   <= '0;
        end else begin
            r_ack    <= '0;
            r_done   <= '0;
            r_rvalid <= '0;

            if (w_grant) begin
                r_cur  <= w_winner;
                r_ptr  <= w_winner;
                r_wr   <= bus.cl_wr[w_winner];
                r_addr <= w_addr_arr[w_winner];
                r_len  <= clamp_len(w_len_arr[w_winner]);
                r_ack  <= onehot(w_winner);
            end

            if (r_state == ST_GRANT) r_beats <= '0;

            if (w_ddr_start) begin
                if (r_wr) begin
                    r_wr_req  <= 1'b1;
                    r_wr_len  <= r_len;
                    r_wr_addr <= r_addr;
                end else begin
                    r_rd_req  <= 1'b1;
                    r_rd_len  <= r_len;
                    r_rd_addr <= r_addr;
                end
            end

            if (w_burst_end) begin
                r_rd_req <= 1'b0;
                r_wr_req <= 1'b0;
            end

            if (r_state == ST_BURST) begin
                if (r_wr && bus.wr_burst_data_req) begin
                    r_wdata <= widen_wdata(w_wdata_arr[r_cur]);
                    r_beats <= r_beats + 1'b1;
                end
                // Beats past the latched length are swallowed.
                if (!r_wr && bus.rd_burst_data_valid && (r_beats < r_len)) begin
                    r_rdata  <= bus.rd_burst_data[CL_DATA_WIDTH-1:0];
                    r_rvalid <= onehot(r_cur);
                    r_beats  <= r_beats + 1'b1;
                end
            end

            if ((w_state_nxt == ST_FINISH) && (r_state != ST_FINISH)) r_done <= onehot(r_cur);
        end
    end

    assign bus.cl_ack        = r_ack;
    assign bus.cl_done       = r_done;
    assign bus.cl_rvalid     = r_rvalid;
    assign bus.cl_rdata      = r_rdata;
    assign bus.cl_wdata_req  = ((r_state == ST_BURST) && r_wr && bus.wr_burst_data_req)
                               ? onehot(r_cur) : '0;
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.cur_client    = r_cur;
    assign bus.rd_burst_req  = r_rd_req;
    assign bus.wr_burst_req  = r_wr_req;
    assign bus.rd_burst_len  = r_rd_len;
    assign bus.wr_burst_len  = r_wr_len;
    assign bus.rd_burst_addr = r_rd_addr;
    assign bus.wr_burst_addr = r_wr_addr;
    assign bus.wr_burst_data = r_wdata;
endmodule
